// File: rtl/ula_flag_wb.sv
// ula_flag_wb: result/flag stage downstream of the logic ALU.
// The stage holds two results in a FIFO for the register-file write port.
// It keeps the architectural O/C/S/Z flags and commits them when a result
// is accepted, not when it is written back.
// Branch conditions are evaluated only against the committed flags.
module ula_flag_wb #(
   parameter int bits      = 16,
   parameter int REGS_ADDR = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   // upstream (ALU) side
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [bits-1:0]      RESU,
   input  logic                 O,
   input  logic                 C,
   input  logic                 S,
   input  logic                 Z,
   input  logic [4:0]           OP,
   input  logic [REGS_ADDR-1:0] RD,
   input  logic                 WE,
   // register-file write port
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [bits-1:0]      WB_DATA,
   output logic [REGS_ADDR-1:0] WB_ADDR,
   output logic                 WB_EN,
   // flags and branch condition
   output logic [3:0]           FLAGS,
   input  logic [2:0]           COND,
   output logic                 COND_TRUE
);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [bits-1:0]      r_data [0:1];
   logic [REGS_ADDR-1:0] r_addr [0:1];
   logic [1:0]           r_we;
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;

   // Committed flags. Bit order is {O,C,S,Z}.
   logic                 r_o;
   logic                 r_c;
   logic                 r_s;
   logic                 r_z;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;

   assign w_in_ready  = (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = IN_VALID & w_in_ready;
   assign w_pop       = w_out_valid & OUT_READY;

   // ------------------------------------------------------------------
   // Flag update enables, decoded from the opcode class
   // ------------------------------------------------------------------
   logic w_upd_o;
   logic w_upd_c;
   logic w_upd_s;
   logic w_upd_z;

   // Decide which flags the incoming opcode is allowed to overwrite.
   always_comb begin
      w_upd_o = 1'b0;
      w_upd_c = 1'b0;
      w_upd_s = 1'b0;
      w_upd_z = 1'b0;
      if (OP == 5'b10011 || OP == 5'b11111) begin
         // pass B and const 1 leave all flags alone
      end else if (OP == 5'b10000) begin
         // zero: only Z follows the result
         w_upd_z = 1'b1;
      end else if (OP == 5'b01000 || OP == 5'b01001) begin
         // shifts carry the shifted-out bit in C; O is kept
         w_upd_z = 1'b1;
         w_upd_s = 1'b1;
         w_upd_c = 1'b1;
      end else if (OP[4]) begin
         // remaining logic ops never produce carry or overflow
         w_upd_z = 1'b1;
         w_upd_s = 1'b1;
      end else if (OP[4:3] == 2'b00) begin
         // arithmetic unit owns all four flags
         w_upd_z = 1'b1;
         w_upd_s = 1'b1;
         w_upd_c = 1'b1;
         w_upd_o = 1'b1;
      end
      // other 01xxx codes: no flag change
   end

   // ------------------------------------------------------------------
   // FIFO state: pointers, count and entry storage
   // ------------------------------------------------------------------

   // Advance pointers and count; reset drops everything in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Write the accepted entry into the slot under the write pointer.
   // Stale contents are masked at the outputs when the FIFO is empty,
   // so the storage itself needs no reset.
   always_ff @(posedge CLK) begin
      if (!RST && w_push) begin
         r_data[r_wr_ptr] <= RESU;
         r_addr[r_wr_ptr] <= RD;
         r_we[r_wr_ptr]   <= WE;
      end
   end

   // ------------------------------------------------------------------
   // Architectural flags, committed at push time
   // ------------------------------------------------------------------

   // Overwrite only the flags this opcode class owns.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_o <= 1'b0;
         r_c <= 1'b0;
         r_s <= 1'b0;
         r_z <= 1'b0;
      end else if (w_push) begin
         if (w_upd_o) r_o <= O;
         if (w_upd_c) r_c <= C;
         if (w_upd_s) r_s <= S;
         if (w_upd_z) r_z <= Z;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign IN_READY  = w_in_ready;
   assign OUT_VALID = w_out_valid;
   assign FLAGS     = {r_o, r_c, r_s, r_z};

   // Present the head entry, forcing zeros when nothing is held.
   always_comb begin
      WB_DATA = '0;
      WB_ADDR = '0;
      WB_EN   = 1'b0;
      if (w_out_valid) begin
         WB_DATA = r_data[r_rd_ptr];
         WB_ADDR = r_addr[r_rd_ptr];
         WB_EN   = OUT_READY & r_we[r_rd_ptr];
      end
   end

   // Branch condition on committed flags only. A push this cycle does not
   // affect the result until after the edge.
   always_comb begin
      COND_TRUE = 1'b0;
      case (COND)
         3'b000:  COND_TRUE = 1'b1;
         3'b001:  COND_TRUE = r_z;
         3'b010:  COND_TRUE = ~r_z;
         3'b011:  COND_TRUE = r_s;
         3'b100:  COND_TRUE = ~r_s;
         3'b101:  COND_TRUE = r_c;
         3'b110:  COND_TRUE = r_o;
         default: COND_TRUE = 1'b0;
      endcase
   end

endmodule
